vsm_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-bit VSM data bus. Bus sources, such as the input register and the accumulator/ALU output register, drive the bus through tri-state buffers enabled by a single active-high enable each. This block grants the bus to one source at a time, drives that source's enable, and limits burst length. It inserts one all-off turnaround cycle between owners so two buffers never drive the bus in the same cycle.

---
 rtl/vsm_bus_arbiter_if.sv | 28 ++
 rtl/vsm_bus_arbiter.sv | 102 ++++++++++
 tb/tb_vsm_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vsm_bus_arbiter_if.sv
// Bus-source request/enable bundle for the shared VSM data bus.
// master = arbiter side, slave = bus sources and sinks.
interface vsm_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0] Req;
  logic [NREQ-1:0] Enable;
  logic [IDW-1:0]  GrantId;
  logic            BusValid;
  logic            Preempt;

  modport master (
    input  Req,
    output Enable,
    output GrantId,
    output BusValid,
    output Preempt
  );

  modport slave (
    output Req,
    input  Enable,
    input  GrantId,
    input  BusValid,
    input  Preempt
  );
endinterface

// File: rtl/vsm_bus_arbiter.sv
// Round-robin tri-state bus arbiter for the VSM data bus.
// One owner at a time, burst-limited, one dead cycle per handover.
module vsm_bus_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input logic               Clock,
  input logic               ResetN,
  vsm_bus_arbiter_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]      state;
  logic [NREQ-1:0] enable;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  ptr;
  logic [3:0]      burst_cnt;
  logic            bus_valid;
  logic            preempt;

  logic            any_req;
  logic            own_req;
  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW:0]    cand;

  assign any_req = |bus.Req;
  assign own_req = |(bus.Req & enable);

  // Search Ptr+1 .. Ptr+NREQ, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!win_found && bus.Req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      enable    <= '0;
      grant_id  <= '0;
      ptr       <= IDW'(NREQ - 1);
      burst_cnt <= '0;
      bus_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, TURN: begin
          preempt <= 1'b0;
          if (any_req && win_found) begin
            state     <= DRIVE;
            enable    <= NREQ'(1) << win_id;
            grant_id  <= win_id;
            ptr       <= win_id;
            burst_cnt <= 4'd1;
            bus_valid <= 1'b1;
          end else begin
            state     <= IDLE;
            enable    <= '0;
            bus_valid <= 1'b0;
          end
        end
        DRIVE: begin
          if (own_req && (burst_cnt < 4'(MAX_BURST))) begin
            burst_cnt <= burst_cnt + 4'd1;
          end else begin
            // Release or burst limit: float the bus for one cycle.
            state     <= TURN;
            enable    <= '0;
            bus_valid <= 1'b0;
            preempt   <= own_req;
          end
        end
        default: begin
          state     <= IDLE;
          enable    <= '0;
          bus_valid <= 1'b0;
          preempt   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Enable   = enable;
  assign bus.GrantId  = grant_id;
  assign bus.BusValid = bus_valid;
  assign bus.Preempt  = preempt;

endmodule

// File: tb/tb_vsm_bus_arbiter.sv
// Self-checking bench for vsm_bus_arbiter: directed scenarios
// plus a randomized sweep against an owner/pointer reference model.
module tb_vsm_bus_arbiter;
  localparam int NREQ = 3;
  localparam int MB   = 4;

  logic Clock;
  logic ResetN;
  int   errors;
  int   checks;

  int   m_owner;
  int   m_cnt;
  int   m_ptr;
  int   m_gid;
  bit   m_pre;

  vsm_bus_arbiter_if #(.NREQ(NREQ)) bus_if ();

  vsm_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  function automatic int pick(input int p, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = NREQ - 1;
    m_gid   = 0;
    m_pre   = 1'b0;
  endtask

  // An owner keeps the bus while requesting and under the burst limit;
  // leaving always costs one idle cycle before anyone is granted.
  task automatic model_step(input logic [NREQ-1:0] r);
    int w;
    m_pre = 1'b0;
    if (m_owner >= 0) begin
      if (r[m_owner] && m_cnt < MB) begin
        m_cnt++;
      end else begin
        m_pre   = r[m_owner];
        m_owner = -1;
      end
    end else begin
      w = pick(m_ptr, r);
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_gid   = w;
        m_cnt   = 1;
      end
    end
  endtask

  function automatic logic [NREQ-1:0] m_enable();
    if (m_owner < 0) return '0;
    return NREQ'(1) << m_owner;
  endfunction

  task automatic cyc(input logic [NREQ-1:0] r);
    @(negedge Clock);
    bus_if.Req = r;
    @(posedge Clock);
    if (ResetN) model_step(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    ResetN     = 1'b0;
    bus_if.Req = '0;
    model_reset();
    @(negedge Clock);
    ResetN = 1'b1;
  endtask

  task automatic test_reset();
    ResetN     = 1'b0;
    bus_if.Req = '0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if ({bus_if.Enable, bus_if.GrantId, bus_if.BusValid, bus_if.Preempt}
        !== {3'b000, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: en=%b gid=%0d bv=%b pre=%b want 000/0/0/0",
               bus_if.Enable, bus_if.GrantId, bus_if.BusValid,
               bus_if.Preempt);
    end
    @(negedge Clock);
    ResetN = 1'b1;
    cyc(3'b010);
    checks++;
    if (bus_if.Enable !== 3'b010) begin
      errors++;
      $display("FAIL reset_pre_grant: en=%b want 010", bus_if.Enable);
    end
    #2;
    ResetN = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus_if.Enable, bus_if.BusValid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: en=%b bv=%b want 000/0",
               bus_if.Enable, bus_if.BusValid);
    end
    @(negedge Clock);
    ResetN     = 1'b1;
    bus_if.Req = 3'b111;
    @(posedge Clock);
    model_step(3'b111);
    #1;
    checks++;
    if ({bus_if.Enable, bus_if.GrantId} !== {3'b001, 2'd0}) begin
      errors++;
      $display("FAIL reset_first_grant: en=%b gid=%0d want 001/0",
               bus_if.Enable, bus_if.GrantId);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] req_t [4];
    logic [NREQ-1:0] en_t  [4];
    req_t = '{3'b100, 3'b100, 3'b000, 3'b000};
    en_t  = '{3'b100, 3'b100, 3'b000, 3'b000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(req_t[i]);
      checks++;
      if ({bus_if.Enable, bus_if.GrantId, bus_if.Preempt}
          !== {en_t[i], 2'd2, 1'b0}) begin
        errors++;
        $display("FAIL single[%0d]: en=%b gid=%0d pre=%b want %b/2/0",
                 i, bus_if.Enable, bus_if.GrantId, bus_if.Preempt, en_t[i]);
      end
    end
  endtask

  task automatic test_preempt();
    logic [NREQ-1:0] en_x;
    logic            pre_x;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(3'b001);
      en_x  = (c % 5 < 4) ? 3'b001 : 3'b000;
      pre_x = (c % 5 == 4);
      checks++;
      if ({bus_if.Enable, bus_if.Preempt, bus_if.BusValid}
          !== {en_x, pre_x, |en_x}) begin
        errors++;
        $display("FAIL preempt[%0d]: en=%b pre=%b bv=%b want %b/%b/%b",
                 c, bus_if.Enable, bus_if.Preempt, bus_if.BusValid,
                 en_x, pre_x, |en_x);
      end
      checks++;
      if (bus_if.BusValid && bus_if.Preempt) begin
        errors++;
        $display("FAIL preempt_overlap[%0d]: bv=1 pre=1 want not both", c);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] en_x;
    do_reset();
    for (int c = 0; c < 19; c++) begin
      cyc(3'b111);
      en_x = (c % 5 < 4) ? (NREQ'(1) << ((c / 5) % 3)) : '0;
      checks++;
      if (bus_if.Enable !== en_x) begin
        errors++;
        $display("FAIL rr[%0d]: en=%b want %b", c, bus_if.Enable, en_x);
      end
    end
  endtask

  task automatic test_handover();
    do_reset();
    cyc(3'b010);
    cyc(3'b010);
    checks++;
    if ({bus_if.Enable, bus_if.GrantId} !== {3'b010, 2'd1}) begin
      errors++;
      $display("FAIL handover_own: en=%b gid=%0d want 010/1",
               bus_if.Enable, bus_if.GrantId);
    end
    cyc(3'b101);
    checks++;
    if ({bus_if.Enable, bus_if.Preempt} !== {3'b000, 1'b0}) begin
      errors++;
      $display("FAIL handover_turn: en=%b pre=%b want 000/0",
               bus_if.Enable, bus_if.Preempt);
    end
    cyc(3'b101);
    checks++;
    if ({bus_if.Enable, bus_if.GrantId} !== {3'b100, 2'd2}) begin
      errors++;
      $display("FAIL handover_next: en=%b gid=%0d want 100/2",
               bus_if.Enable, bus_if.GrantId);
    end
  endtask

  task automatic test_sweep();
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] en_x;
    do_reset();
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge Clock);
      if ($urandom_range(0, 3) == 0) r = NREQ'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        ResetN = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus_if.Enable, bus_if.BusValid, bus_if.GrantId} !== 6'b0) begin
          errors++;
          $display("FAIL sweep_reset[%0d]: en=%b bv=%b gid=%0d want 0",
                   c, bus_if.Enable, bus_if.BusValid, bus_if.GrantId);
        end
        #1;
        ResetN = 1'b1;
      end
      bus_if.Req = r;
      @(posedge Clock);
      model_step(r);
      #1;
      en_x = m_enable();
      checks++;
      if ({bus_if.Enable, bus_if.GrantId, bus_if.BusValid, bus_if.Preempt}
          !== {en_x, 2'(m_gid), |en_x, m_pre}) begin
        errors++;
        $display("FAIL sweep[%0d]: en=%b gid=%0d bv=%b pre=%b want %b/%0d/%b/%b",
                 c, bus_if.Enable, bus_if.GrantId, bus_if.BusValid,
                 bus_if.Preempt, en_x, m_gid, |en_x, m_pre);
      end
      checks++;
      if (!$onehot0(bus_if.Enable) || (bus_if.BusValid !== |bus_if.Enable)) begin
        errors++;
        $display("FAIL sweep_invariant[%0d]: en=%b bv=%b want onehot0, bv=|en",
                 c, bus_if.Enable, bus_if.BusValid);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_preempt();
    test_round_robin();
    test_handover();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
